jk_seq_driver: RTL and testbench

Excitation-side driver for a bank of JK flip-flops. It holds a small table of target states and, for each step, computes the J/K inputs that move the bank from its current state (`q_fb`) to the next target, using the JK excitation table. After each step it checks the fed-back state against the target. It sits in front of a `WIDTH`-bit array of JK flip-flops sharing `clock`, and is used for sequence generation and for self-checking the flop bank.

---
 rtl/jk_pkg.sv | 17 +
 rtl/jk_excite_bit.sv | 19 +
 rtl/jk_seq_driver.sv | 147 ++++++++++++++
 tb/tb_jk_seq_driver.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared types and constants for the JK flip-flop bank sequence driver.
package jk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } jk_state_e;

  // {J, K} pairs; don't-care excitations are resolved to these three.
  localparam logic [1:0] JK_HOLD  = 2'b00;
  localparam logic [1:0] JK_SET   = 2'b10;
  localparam logic [1:0] JK_RESET = 2'b01;

endpackage

// File: rtl/jk_excite_bit.sv
// Excitation for one JK flop: the {J, K} pair that moves q to target.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic       q,
  input  logic       target,
  output logic [1:0] jk
);

  always_comb begin
    jk = JK_HOLD;
    if (!q && target) begin
      jk = JK_SET;
    end else if (q && !target) begin
      jk = JK_RESET;
    end
  end

endmodule

// File: rtl/jk_seq_driver.sv
// Steps a JK flop bank through a table of target states and checks each step.
// Handshake: start/stop/wr_en are single-cycle strobes sampled on the rising clock edge.
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [AW-1:0]      last_idx,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   q_fb,
  output logic [2*WIDTH-1:0] jk,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [WIDTH-1:0]   err_bits,
  output logic [AW-1:0]      step_idx,
  output jk_state_e          state_dbg
);

  jk_state_e          state;
  logic [WIDTH-1:0]   tbl [DEPTH];
  logic [AW-1:0]      last_q;
  logic               loop_q;
  logic [AW-1:0]      drive_idx;
  logic [WIDTH-1:0]   drive_tgt;
  logic [2*WIDTH-1:0] drive_jk;
  logic [WIDTH-1:0]   cur_tgt;
  logic               mismatch;

  assign state_dbg = state;
  assign cur_tgt   = tbl[step_idx];
  assign mismatch  = (q_fb != cur_tgt);

  // jk is registered, so the excitation for the step being entered is
  // computed from the index that step will use.
  always_comb begin
    drive_idx = '0;
    if (state == ST_CHECK && step_idx != last_q) begin
      drive_idx = step_idx + AW'(1);
    end
  end

  assign drive_tgt = tbl[drive_idx];

  for (genvar i = 0; i < WIDTH; i++) begin : g_excite
    jk_excite_bit u_bit (
      .q      (q_fb[i]),
      .target (drive_tgt[i]),
      .jk     (drive_jk[2*i+1:2*i])
    );
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state    <= ST_IDLE;
      jk       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_bits <= '0;
      step_idx <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      jk   <= '0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_en) begin
            tbl[wr_addr] <= wr_data;
          end
          if (start && !stop) begin
            state    <= ST_DRIVE;
            step_idx <= '0;
            last_q   <= last_idx;
            loop_q   <= loop;
            jk       <= drive_jk;
            busy     <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (mismatch) begin
            state    <= ST_ERROR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_bits <= q_fb ^ cur_tgt;
          end else if (step_idx != last_q || loop_q) begin
            state    <= ST_DRIVE;
            step_idx <= drive_idx;
            jk       <= drive_jk;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_ERROR: begin
          if (stop) begin
            state    <= ST_IDLE;
            error    <= 1'b0;
            err_bits <= '0;
          end else if (start) begin
            state    <= ST_DRIVE;
            step_idx <= '0;
            last_q   <= last_idx;
            loop_q   <= loop;
            jk       <= drive_jk;
            busy     <= 1'b1;
            error    <= 1'b0;
            err_bits <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver with a behavioural 4-flop JK bank on jk/q_fb.
module tb_jk_seq_driver;
  import jk_pkg::*;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int EW = 2*W + AW + 3;

  logic              clock;
  logic              clear_n;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic [AW-1:0]     last_idx;
  logic              loop;
  logic              start;
  logic              stop;
  logic [W-1:0]      q_fb;
  logic [2*W-1:0]    jk;
  logic              busy;
  logic              done;
  logic              error;
  logic [W-1:0]      err_bits;
  logic [AW-1:0]     step_idx;
  jk_state_e         state_dbg;

  logic [W-1:0]      bank;
  logic [W-1:0]      stuck;

  logic [EW-1:0]     exp_q[$];
  logic [W-1:0]      m_tbl [D];
  logic [W-1:0]      pb;
  logic [W-1:0]      perr;
  int                n_tests;
  int                n_fail;

  jk_seq_driver #(.WIDTH(W), .DEPTH(D)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .last_idx  (last_idx),
    .loop      (loop),
    .start     (start),
    .stop      (stop),
    .q_fb      (q_fb),
    .jk        (jk),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_bits  (err_bits),
    .step_idx  (step_idx),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / bank ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    logic [W-1:0] nxt;
    nxt = bank;
    for (int i = 0; i < W; i++) begin
      case ({jk[2*i+1], jk[2*i]})
        2'b10:   nxt[i] = 1'b1;
        2'b01:   nxt[i] = 1'b0;
        2'b11:   nxt[i] = ~bank[i];
        default: nxt[i] = bank[i];
      endcase
    end
    bank <= nxt & ~stuck;
  end

  assign q_fb = bank & ~stuck;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] exp_jk(input logic [W-1:0] q, input logic [W-1:0] t);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (!q[i] && t[i]) r[2*i+1] = 1'b1;
      else if (q[i] && !t[i]) r[2*i] = 1'b1;
    end
    return r;
  endfunction

  task automatic push(input logic [2*W-1:0] j, input int idx, input bit b, input bit d, input bit e);
    exp_q.push_back({j, AW'(idx), b, d, e});
  endtask

  // Expected per-cycle observations for a run from entry 0.
  task automatic predict_run(input int last, input bit lp, input int nsteps);
    int idx;
    logic [W-1:0] t;
    idx = 0;
    for (int s = 0; s < nsteps; s++) begin
      t = m_tbl[idx];
      push(exp_jk(pb, t), idx, 1'b1, 1'b0, 1'b0);
      pb = t & ~stuck;
      push('0, idx, 1'b1, 1'b0, 1'b0);
      if (pb != t) begin
        perr = pb ^ t;
        push('0, idx, 1'b0, 1'b0, 1'b1);
        push('0, idx, 1'b0, 1'b0, 1'b1);
        return;
      end
      if (idx == last) begin
        if (!lp) begin
          push('0, idx, 1'b1, 1'b1, 1'b0);
          push('0, idx, 1'b0, 1'b0, 1'b0);
          return;
        end
        idx = 0;
      end else begin
        idx++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input int addr, input logic [W-1:0] data);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    @(negedge clock);
    wr_en = 1'b0;
    m_tbl[addr] = data;
  endtask

  task automatic go(input int last, input bit lp);
    @(negedge clock);
    last_idx = AW'(last); loop = lp; start = 1'b1;
  endtask

  // kind: 1 stop, 2 write entry 0 + start, 3 start+stop
  task automatic drain(input int act_at, input int kind);
    int n;
    logic [EW-1:0] e;
    n = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      start = 1'b0; stop = 1'b0; wr_en = 1'b0;
      e = exp_q.pop_front();
      chk($sformatf("cyc%0d", n), {jk, step_idx, busy, done, error}, e);
      if (n == act_at) begin
        case (kind)
          1: stop = 1'b1;
          2: begin wr_en = 1'b1; wr_addr = '0; wr_data = '1; start = 1'b1; end
          3: begin start = 1'b1; stop = 1'b1; end
          default: ;
        endcase
      end
      n++;
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a;
    n_tests = 0; n_fail = 0;
    clear_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    last_idx = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    bank = '0; stuck = '0; pb = '0; perr = '0;
    for (int i = 0; i < D; i++) m_tbl[i] = '0;

    #2;
    chk("rst_jk", jk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_step", step_idx, 0);
    chk("rst_state", state_dbg, ST_IDLE);
    #5 clear_n = 1'b1;

    // Four-step ramp, no loop.
    wr(0, 4'b0001); wr(1, 4'b0011); wr(2, 4'b0111); wr(3, 4'b1111);
    predict_run(3, 1'b0, 4);
    go(3, 1'b0);
    drain(-1, 0);
    chk("ramp_q", q_fb, 4'b1111);

    // Two-entry loop, stopped during the third pass of entry 0.
    wr(0, 4'b1010); wr(1, 4'b0101);
    predict_run(1, 1'b1, 4);
    push(exp_jk(pb, m_tbl[0]), 0, 1'b1, 1'b0, 1'b0);
    pb = m_tbl[0];
    a = exp_q.size() - 1;
    push('0, 0, 1'b0, 1'b0, 1'b0);
    push('0, 0, 1'b0, 1'b0, 1'b0);
    go(1, 1'b1);
    drain(a, 1);

    // Flop 2 stuck at 0.
    wr(0, 4'b0001); wr(1, 4'b0101);
    stuck = 4'b0100;
    predict_run(1, 1'b0, 2);
    go(1, 1'b0);
    drain(-1, 0);
    chk("err_bits", err_bits, perr);
    predict_run(1, 1'b0, 2);
    a = exp_q.size() - 1;
    push('0, 1, 1'b0, 1'b0, 1'b0);
    push('0, 1, 1'b0, 1'b0, 1'b0);
    go(1, 1'b0);
    drain(a, 1);
    stuck = '0;
    chk("err_clear", err_bits, 0);

    // Write and start while busy are ignored.
    predict_run(1, 1'b0, 2);
    go(1, 1'b0);
    drain(1, 2);
    predict_run(1, 1'b0, 2);
    go(1, 1'b0);
    drain(-1, 0);
    push('0, 1, 1'b0, 1'b0, 1'b0);
    push('0, 1, 1'b0, 1'b0, 1'b0);
    push('0, 1, 1'b0, 1'b0, 1'b0);
    drain(0, 3);

    // Asynchronous reset in the middle of DRIVE.
    wr(0, 4'b1110);
    go(3, 1'b0);
    @(negedge clock);
    start = 1'b0;
    chk("pre_rst_jk", jk, exp_jk(pb, m_tbl[0]));
    chk("pre_rst_busy", busy, 1);
    #2 clear_n = 1'b0;
    #1;
    chk("arst_jk", jk, 0);
    chk("arst_busy", busy, 0);
    chk("arst_step", step_idx, 0);
    chk("arst_state", state_dbg, ST_IDLE);
    @(negedge clock);
    clear_n = 1'b1;
    for (int i = 0; i < D; i++) m_tbl[i] = '0;
    predict_run(3, 1'b0, 4);
    go(3, 1'b0);
    drain(-1, 0);
    chk("cleared_q", q_fb, pb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
